// File: rtl/hp_sweep_ctrl.sv
// hp_sweep_ctrl
//   Wishbone-programmable glitch-sweep sequencer for the hoggephase detector
//   pair and the programmable glitcher. For every offset in [off_start,off_end]
//   (stepping by `step`) it runs `repeats` trials (clear, arm for `window`
//   cycles, sample alarm, settle). It then pushes one result word per offset
//   into a FIFO that firmware drains over wishbone.
//
// Ports
//   wb_clk_i, reset_n        clock, async active-low reset
//   wbs_*                    wishbone slave (32-byte window at BASE_ADDRESS)
//   alarm_latch_i            detector latched alarm (foreign domain)
//   alarm_ctr_i[7:0]         detector alarm counter (foreign domain)
//   hp_vcc_o, hp_pn_select_o detector VCC enable / detector select (CTRL mirror)
//   hp_alarm_rst_o           alarm latch clear
//   hp_alarm_ctr_rst_o       alarm counter clear
//   hp_glitch_en_o           glitcher enable
//   hp_glitch_offset_o       glitcher offset for the current trial
//   busy_o, done_o           campaign running / sticky campaign done
module hp_sweep_ctrl #(
   parameter logic [31:0] BASE_ADDRESS  = 32'h3000_0100,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned CLR_CYCLES    = 2,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        wb_clk_i,
   input  logic        reset_n,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic        wbs_stl_o,
   output logic [31:0] wbs_dat_o,
   input  logic        alarm_latch_i,
   input  logic [7:0]  alarm_ctr_i,
   output logic        hp_vcc_o,
   output logic        hp_alarm_rst_o,
   output logic        hp_alarm_ctr_rst_o,
   output logic        hp_glitch_en_o,
   output logic [15:0] hp_glitch_offset_o,
   output logic [1:0]  hp_pn_select_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam int unsigned AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FIFO_FULL   = (AW + 1)'(FIFO_DEPTH);
   localparam logic [15:0] CLR_LAST    = 16'(CLR_CYCLES - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_ARM    = 3'd2,
      S_SAMPLE = 3'd3,
      S_SETTLE = 3'd4,
      S_NEXT   = 3'd5,
      S_PUSH   = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   state_t state, state_nxt;

   // ---------------- synchronizers ----------------
   logic       latch_s1, latch_s2;
   logic [7:0] ctr_s1, ctr_s2;

   // The counter second stage only advances while the latch is not changing,
   // so the captured count is consistent with the captured latch value.
   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         latch_s1 <= 1'b0;
         latch_s2 <= 1'b0;
         ctr_s1   <= '0;
         ctr_s2   <= '0;
      end else begin
         latch_s1 <= alarm_latch_i;
         latch_s2 <= latch_s1;
         ctr_s1   <= alarm_ctr_i;
         if (latch_s1 == latch_s2) ctr_s2 <= ctr_s1;
      end
   end

   // ---------------- bus decode ----------------
   logic       in_win, req, wr, rd;
   logic [2:0] word;
   logic       start_p, abort_p, done_clr_p;
   logic       unused_adr;

   assign in_win     = (wbs_adr_i[31:5] == BASE_ADDRESS[31:5]);
   // Gating with ack keeps the ack a single-cycle pulse while stb is still held.
   assign req        = wbs_cyc_i & wbs_stb_i & in_win & ~wbs_ack_o;
   assign wr         = req & wbs_we_i;
   assign rd         = req & ~wbs_we_i;
   assign word       = wbs_adr_i[4:2];
   assign start_p    = wr && (word == 3'd0) && wbs_dat_i[0];
   assign abort_p    = wr && (word == 3'd0) && wbs_dat_i[1];
   assign done_clr_p = wr && (word == 3'd0) && wbs_dat_i[3];
   assign unused_adr = ^wbs_adr_i[1:0];

   // ---------------- registers ----------------
   logic        vcc;
   logic [1:0]  pn_sel;
   logic [15:0] off_start, off_end, window;
   logic [7:0]  step, repeats;
   logic [7:0]  step_e, rep_e;
   logic [15:0] win_e;

   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         vcc       <= 1'b0;
         pn_sel    <= '0;
         off_start <= '0;
         off_end   <= '0;
         step      <= '0;
         repeats   <= '0;
         window    <= '0;
      end else if (wr) begin
         if (word == 3'd0) begin
            vcc    <= wbs_dat_i[2];
            pn_sel <= wbs_dat_i[15:14];
         end
         if (word == 3'd1 && !busy_o) begin
            off_start <= wbs_dat_i[15:0];
            off_end   <= wbs_dat_i[31:16];
         end
         if (word == 3'd2 && !busy_o) begin
            step    <= wbs_dat_i[7:0];
            repeats <= wbs_dat_i[15:8];
            window  <= wbs_dat_i[31:16];
         end
      end
   end

   assign step_e = (step == '0)    ? 8'd1  : step;
   assign rep_e  = (repeats == '0) ? 8'd1  : repeats;
   assign win_e  = (window == '0)  ? 16'd1 : window;

   // ---------------- result FIFO ----------------
   logic [31:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          fifo_empty, fifo_full, push, pop;
   logic [15:0]   offset;
   logic [7:0]    trial, hits, ctr_cap;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FIFO_FULL);
   assign pop        = rd && (word == 3'd4) && !fifo_empty;

   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {ctr_cap, hits, offset};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------- sequencer ----------------
   logic [15:0] cnt;
   logic [16:0] sum17;
   logic        last_trial, last_off, done;

   assign sum17      = {1'b0, offset} + {9'd0, step_e};
   assign last_off   = (sum17 > {1'b0, off_end});
   assign last_trial = (trial >= rep_e - 8'd1);

   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         S_IDLE:   if (start_p) state_nxt = (off_start > off_end) ? S_DONE : S_CLEAR;
         S_CLEAR:  if (cnt == CLR_LAST) state_nxt = S_ARM;
         S_ARM:    if (cnt == win_e - 16'd1) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = S_SETTLE;
         S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_NEXT;
         S_NEXT:   state_nxt = last_trial ? S_PUSH : S_CLEAR;
         S_PUSH: begin
            if (!fifo_full) begin
               push      = 1'b1;
               state_nxt = last_off ? S_DONE : S_CLEAR;
            end
         end
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (abort_p) begin
         state_nxt = S_IDLE;
         push      = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         offset  <= '0;
         trial   <= '0;
         hits    <= '0;
         ctr_cap <= '0;
         done    <= 1'b0;
      end else begin
         cnt <= (state_nxt != state) ? '0 : cnt + 16'd1;
         case (state)
            S_IDLE: begin
               if (start_p) begin
                  offset <= off_start;
                  trial  <= '0;
                  hits   <= '0;
               end
            end
            S_SAMPLE: begin
               if (latch_s2 && hits != 8'hFF) hits <= hits + 8'd1;
               ctr_cap <= ctr_s2;
            end
            S_NEXT:  if (!last_trial) trial <= trial + 8'd1;
            default: ;
         endcase
         if (push) begin
            trial <= '0;
            hits  <= '0;
            if (!last_off) offset <= sum17[15:0];
         end
         if (state == S_DONE && !abort_p) done <= 1'b1;
         else if (start_p || done_clr_p)  done <= 1'b0;
      end
   end

   assign busy_o             = (state != S_IDLE);
   assign done_o             = done;
   assign hp_vcc_o           = vcc;
   assign hp_pn_select_o     = pn_sel;
   assign hp_alarm_rst_o     = (state == S_CLEAR);
   assign hp_alarm_ctr_rst_o = (state == S_CLEAR);
   assign hp_glitch_en_o     = (state == S_ARM);
   assign hp_glitch_offset_o = busy_o ? offset : '0;
   assign wbs_stl_o          = 1'b0;

   // ---------------- read mux / ack ----------------
   logic [31:0] rdata;

   always_comb begin
      rdata = '0;
      case (word)
         3'd0: begin
            rdata[2]     = vcc;
            rdata[15:14] = pn_sel;
         end
         3'd1: rdata = {off_end, off_start};
         3'd2: rdata = {window, repeats, step};
         3'd3: rdata = {hp_glitch_offset_o, 9'd0, state, fifo_full, fifo_empty, done, busy_o};
         3'd4: rdata = fifo_empty ? '0 : mem[rd_ptr];
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= req;
         wbs_dat_o <= rd ? rdata : '0;
      end
   end

endmodule

// File: tb/tb_hp_sweep_ctrl.sv
// tb_hp_sweep_ctrl
//   Self-checking bench for hp_sweep_ctrl: directed campaigns plus randomized
//   campaigns, with an offset/hit list model and a per-cycle output monitor.
module tb_hp_sweep_ctrl;

   localparam logic [31:0] BASE   = 32'h3000_0100;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_RNG  = BASE + 32'h04;
   localparam logic [31:0] A_CFG  = BASE + 32'h08;
   localparam logic [31:0] A_STAT = BASE + 32'h0C;
   localparam logic [31:0] A_RES  = BASE + 32'h10;
   localparam int          CLR    = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, dat_w = '0;
   logic        wbs_ack_o, wbs_stl_o;
   logic [31:0] wbs_dat_o;
   logic        alarm = 1'b0;
   logic [7:0]  actr = '0;
   logic        hp_vcc_o, hp_alarm_rst_o, hp_alarm_ctr_rst_o, hp_glitch_en_o;
   logic [15:0] hp_glitch_offset_o;
   logic [1:0]  hp_pn_select_o;
   logic        busy_o, done_o;

   always #5 clk = ~clk;

   hp_sweep_ctrl #(
      .BASE_ADDRESS (32'h3000_0100),
      .FIFO_DEPTH   (8),
      .CLR_CYCLES   (2),
      .SETTLE_CYCLES(4)
   ) dut (
      .wb_clk_i          (clk),
      .reset_n           (rst_n),
      .wbs_cyc_i         (cyc),
      .wbs_stb_i         (stb),
      .wbs_we_i          (we),
      .wbs_adr_i         (adr),
      .wbs_dat_i         (dat_w),
      .wbs_ack_o         (wbs_ack_o),
      .wbs_stl_o         (wbs_stl_o),
      .wbs_dat_o         (wbs_dat_o),
      .alarm_latch_i     (alarm),
      .alarm_ctr_i       (actr),
      .hp_vcc_o          (hp_vcc_o),
      .hp_alarm_rst_o    (hp_alarm_rst_o),
      .hp_alarm_ctr_rst_o(hp_alarm_ctr_rst_o),
      .hp_glitch_en_o    (hp_glitch_en_o),
      .hp_glitch_offset_o(hp_glitch_offset_o),
      .hp_pn_select_o    (hp_pn_select_o),
      .busy_o            (busy_o),
      .done_o            (done_o)
   );

   int          errors = 0;
   int          checks = 0;
   logic        m_vcc = 1'b0;
   logic [1:0]  m_pn = '0;
   int          m_win = 1;
   int          glitch_total = 0;
   int          cyc_n = 0;
   logic [31:0] exp_q[$];
   int          exp_glitch = 0;
   int          g0 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // ---------------- per-cycle monitor ----------------
   int   g_run = 0, r_run = 0;
   logic ack_prev = 1'b0;

   always @(negedge clk) begin
      cyc_n++;
      if (!rst_n) begin
         g_run = 0;
         r_run = 0;
         ack_prev = 1'b0;
      end else begin
         check("stall", 32'(wbs_stl_o), 32'd0);
         check("vcc", 32'(hp_vcc_o), 32'(m_vcc));
         check("pn_select", 32'(hp_pn_select_o), 32'(m_pn));
         check("clear_pair", 32'(hp_alarm_rst_o), 32'(hp_alarm_ctr_rst_o));
         if (!wbs_ack_o) check("dat_without_ack", wbs_dat_o, 32'd0);
         if (ack_prev) check("ack_single_pulse", 32'(wbs_ack_o), 32'd0);
         if (!busy_o)
            check("idle_outputs", 32'({hp_glitch_en_o, hp_alarm_rst_o, hp_glitch_offset_o}), 32'd0);
         if (hp_glitch_en_o) begin
            g_run++;
            glitch_total++;
            check("glitch_during_clear", 32'(hp_alarm_rst_o), 32'd0);
         end else if (g_run != 0) begin
            check("glitch_window_len", 32'(g_run), 32'(m_win));
            g_run = 0;
         end
         if (hp_alarm_rst_o) r_run++;
         else if (r_run != 0) begin
            check("clear_len", 32'(r_run), 32'(CLR));
            r_run = 0;
         end
         ack_prev = wbs_ack_o;
      end
   end

   // ---------------- bus tasks ----------------
   task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rdat);
      int lat = 0;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!wbs_ack_o && lat < 8);
      rdat = wbs_dat_o;
      check("ack_latency", 32'(lat), 32'd1);
      if (w && a == A_CTRL && wbs_ack_o) begin
         m_vcc = d[2];
         m_pn  = d[15:14];
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] x;
      wb(1'b1, a, d, x);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      wb(1'b0, a, 32'd0, d);
   endtask

   function automatic logic [31:0] ctrl_word(input logic st, input logic ab, input logic dc,
                                              input logic v, input logic [1:0] p);
      ctrl_word = {16'd0, p, 10'd0, dc, v, ab, st};
   endfunction

   // ---------------- reference model ----------------
   // The result list is the arithmetic progression off_start, +step, ... up
   // to off_end (17-bit arithmetic, no wrap); every offset runs `rep` trials
   // whose hits equal rep when the alarm is held high.
   task automatic build_model(input int unsigned s, input int unsigned e, input int unsigned st,
                              input int unsigned rp, input int unsigned wn,
                              input logic al, input logic [7:0] c);
      int unsigned se = (st == 0) ? 1 : st;
      int unsigned re = (rp == 0) ? 1 : rp;
      int unsigned ww = (wn == 0) ? 1 : wn;
      int unsigned off = s;
      int unsigned n = 0;
      exp_q.delete();
      if (s <= e) begin
         while (1) begin
            exp_q.push_back({c, al ? 8'(re) : 8'd0, 16'(off)});
            n++;
            if (off + se > e) break;
            off += se;
         end
      end
      exp_glitch = int'(n * re * ww);
      m_win = int'(ww);
   endtask

   task automatic start_campaign(input logic [15:0] s, input logic [15:0] e, input logic [7:0] st,
                                 input logic [7:0] rp, input logic [15:0] wn, input logic al,
                                 input logic [7:0] c, input logic v, input logic [1:0] p);
      alarm = al;
      actr  = c;
      wr(A_RNG, {e, s});
      wr(A_CFG, {wn, rp, st});
      build_model(s, e, st, rp, wn, al, c);
      g0 = glitch_total;
      wr(A_CTRL, ctrl_word(1'b1, 1'b0, 1'b0, v, p));
      check("after_start_busy", 32'(busy_o), 32'(s <= e));
      check("after_start_done", 32'(done_o), 32'(s > e));
   endtask

   task automatic finish_campaign(input int budget);
      int t0 = cyc_n;
      logic [31:0] st, d;
      logic fin = 1'b0;
      while (!fin && (cyc_n - t0) < budget) begin
         rd(A_STAT, st);
         if (!st[2]) begin
            rd(A_RES, d);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL result_extra: got 0x%08h expected no more results", d);
            end else begin
               check("result", d, exp_q.pop_front());
            end
         end else if (st[1]) begin
            fin = 1'b1;
         end
      end
      check("campaign_finished", 32'(fin), 32'd1);
      check("results_missing", 32'(exp_q.size()), 32'd0);
      check("glitch_cycles", 32'(glitch_total - g0), 32'(exp_glitch));
      check("done_o", 32'(done_o), 32'd1);
      check("busy_o_end", 32'(busy_o), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      int n;
      logic [15:0] s, e;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_outputs", 32'({hp_vcc_o, hp_alarm_rst_o, hp_alarm_ctr_rst_o, hp_glitch_en_o,
                                  hp_glitch_offset_o, hp_pn_select_o, busy_o, done_o, wbs_ack_o}), 32'd0);
      rd(A_STAT, d);
      check("status_after_reset", d, 32'h0000_0004);
      rd(A_CTRL, d);
      check("ctrl_after_reset", d, 32'd0);

      // Reset while the glitcher is armed
      start_campaign(16'h0000, 16'h0000, 8'd1, 8'd1, 16'd100, 1'b1, 8'h11, 1'b1, 2'b10);
      n = 0;
      while (!hp_glitch_en_o && n < 50) begin @(posedge clk); #1; n++; end
      check("t1_reached_arm", 32'(hp_glitch_en_o), 32'd1);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      m_vcc = 1'b0;
      m_pn  = '0;
      #1;
      check("t1_reset_outputs", 32'({hp_vcc_o, hp_alarm_rst_o, hp_alarm_ctr_rst_o, hp_glitch_en_o,
                                     hp_glitch_offset_o, hp_pn_select_o, busy_o, done_o, wbs_ack_o}), 32'd0);
      check("t1_reset_dat", wbs_dat_o, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rd(A_STAT, d);
      check("t1_status", d, 32'h0000_0004);
      rd(A_RNG, d);
      check("t1_range_reset", d, 32'd0);

      // Three offsets, three trials each, alarm high
      start_campaign(16'h0010, 16'h0014, 8'd2, 8'd3, 16'd5, 1'b1, 8'h5A, 1'b1, 2'b01);
      check("t2_model_count", 32'(exp_q.size()), 32'd3);
      check("t2_model_first", exp_q[0], 32'h5A03_0010);
      check("t2_model_last", exp_q[2], 32'h5A03_0014);
      check("t2_model_glitch", 32'(exp_glitch), 32'd45);
      finish_campaign(3000);

      // No wrap at the top of the offset range
      start_campaign(16'hFFFE, 16'hFFFF, 8'd4, 8'd1, 16'd3, 1'b0, 8'hC3, 1'b0, 2'b11);
      check("t3_model_count", 32'(exp_q.size()), 32'd1);
      check("t3_model_word", exp_q[0], 32'hC300_FFFE);
      finish_campaign(2000);

      // FIFO backpressure: stall in PUSH until results are drained
      start_campaign(16'd0, 16'd9, 8'd1, 8'd1, 16'd1, 1'b1, 8'h77, 1'b1, 2'b00);
      n = 0;
      d = '0;
      while (!d[3] && n < 100) begin rd(A_STAT, d); n++; end
      check("t4_full_seen", 32'(d[3]), 32'd1);
      repeat (30) @(posedge clk);
      #1;
      rd(A_STAT, d);
      check("t4_stall_flags", d & 32'h0000_000B, 32'h0000_0009);
      check("t4_stall_offset", 32'(d[31:16]), 32'd8);
      wr(A_RNG, 32'hFFFF_FFFF);
      rd(A_RES, d);
      check("t4_pop0", d, exp_q.pop_front());
      rd(A_RES, d);
      check("t4_pop1", d, exp_q.pop_front());
      finish_campaign(3000);
      rd(A_RNG, d);
      check("t4_range_write_dropped", d, 32'h0009_0000);

      // Abort during SETTLE of offset 3
      start_campaign(16'd0, 16'd9, 8'd1, 8'd1, 16'd2, 1'b0, 8'h33, 1'b0, 2'b01);
      n = 0;
      while (!(hp_glitch_en_o && hp_glitch_offset_o == 16'd3) && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      check("t5_reached_offset3", 32'(hp_glitch_offset_o), 32'd3);
      n = 0;
      while (hp_glitch_en_o && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      wr(A_CTRL, ctrl_word(1'b0, 1'b1, 1'b0, 1'b0, 2'b01));
      check("t5_busy", 32'(busy_o), 32'd0);
      check("t5_done", 32'(done_o), 32'd0);
      while (exp_q.size() > 3) void'(exp_q.pop_back());
      while (exp_q.size() > 0) begin
         rd(A_RES, d);
         check("t5_result", d, exp_q.pop_front());
      end
      rd(A_RES, d);
      check("t5_read_empty", d, 32'd0);
      rd(A_STAT, d);
      check("t5_status", d, 32'h0000_0004);

      // off_start > off_end, unmapped word, done clear
      start_campaign(16'd5, 16'd4, 8'd1, 8'd1, 16'd1, 1'b0, 8'h00, 1'b1, 2'b00);
      finish_campaign(200);
      rd(BASE + 32'h18, d);
      check("unmapped_read", d, 32'd0);
      wr(BASE + 32'h18, 32'hDEAD_BEEF);
      rd(A_CFG, d);
      check("unmapped_write_ignored", d, 32'h0001_0101);
      wr(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b1, 1'b1, 2'b00));
      check("done_clr", 32'(done_o), 32'd0);

      // Randomized campaigns
      for (int i = 0; i < 14; i++) begin
         case ($urandom_range(0, 5))
            0: begin
               s = 16'($urandom_range(1, 65535));
               e = s - 16'($urandom_range(1, int'(s)));
            end
            1: begin
               s = 16'hFFFF - 16'($urandom_range(0, 10));
               e = 16'hFFFF;
            end
            default: begin
               s = 16'($urandom_range(0, 60000));
               e = s + 16'($urandom_range(0, 20));
            end
         endcase
         start_campaign(s, e, 8'($urandom_range(0, 5)), 8'($urandom_range(0, 3)),
                        16'($urandom_range(0, 6)), 1'($urandom), 8'($urandom),
                        1'($urandom), 2'($urandom));
         finish_campaign(20000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #800000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hp_sweep_ctrl.md
Name: hp_sweep_ctrl

Overview:
Wishbone-programmable sequencer that runs glitch-sweep campaigns against the hoggephase detector pair and the programmable glitcher. For each glitch offset in a programmed range it runs N trials: clear alarm latch/counter, arm the glitcher, wait a window, then sample the latched alarm. It pushes one per-offset result word into an internal FIFO, which firmware drains over wishbone. It sits between the wishbone bus and the detector/glitcher datapath and replaces direct firmware bit-banging of the control register.

Parameters:
BASE_ADDRESS, 32'h3000_0100, wishbone base; 32-byte window, decode on adr[31:5], word select adr[4:2]
FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2)
CLR_CYCLES, 2, cycles alarm_rst/ctr_rst are held per trial
SETTLE_CYCLES, 4, idle cycles after each trial with glitch_en low

Ports:
wb_clk_i  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  wishbone control
wbs_adr_i, wbs_dat_i  in  32 each  address / write data
wbs_ack_o  out  1  ack
wbs_stl_o  out  1  tied 0
wbs_dat_o  out  32  read data
alarm_latch_i  in  1  detector latched alarm (user_clock2 domain)
alarm_ctr_i  in  8  detector alarm counter (async domain)
hp_vcc_o  out  1  detector VCC enable
hp_alarm_rst_o, hp_alarm_ctr_rst_o  out  1 each  latch / counter clear
hp_glitch_en_o  out  1  glitcher enable
hp_glitch_offset_o  out  16  glitcher offset for current trial
hp_pn_select_o  out  2  detector select
busy_o  out  1  campaign running
done_o  out  1  sticky done, cleared by start or by writing CTRL[3]=1

Behaviour:
- Reset: all outputs, registers, FIFO and state go to 0 / IDLE. reset_n asserts asynchronously and deasserts synchronously.
- alarm_latch_i: 2-flop synchronizer. alarm_ctr_i: 2-flop per bit, sampled only while the latch is stable.
- Registers:
  - 0x00 CTRL (RW): [0] start (self-clearing pulse), [1] abort (pulse), [2] vcc, [3] done_clr (pulse), [15:14] pn_select.
  - 0x04 RANGE: [15:0] off_start, [31:16] off_end.
  - 0x08 CFG: [7:0] step (0 treated as 1), [15:8] repeats (0 treated as 1), [31:16] window (0 treated as 1).
  - 0x0C STATUS (RO): [0] busy, [1] done, [2] empty, [3] full, [6:4] state, [31:16] current offset.
  - 0x10 RESULT (RO, pops): [15:0] offset, [23:16] hits, [31:24] last alarm_ctr sample.
  - Unmapped words read 0; writes to them are ignored.
- Wishbone: ack exactly 1 cycle after cyc&stb&in-window, single-cycle pulse. dat_o is valid with ack and is 0 otherwise.
- Writes to RANGE/CFG while busy are dropped but still acked.
- FSM:
  - IDLE: on start -> CLEAR. If off_start>off_end -> DONE directly, with no results.
  - CLEAR: alarm_rst=ctr_rst=1 for CLR_CYCLES -> ARM.
  - ARM: glitch_en=1 for window cycles -> SAMPLE.
  - SAMPLE: 1 cycle. If synced latch=1, hits += 1 (saturate 255). Capture ctr. -> SETTLE.
  - SETTLE: glitch_en=0 for SETTLE_CYCLES -> NEXT.
  - NEXT: if trial<repeats-1, trial++ -> CLEAR. Else -> PUSH.
  - PUSH: if FIFO full, wait here (glitch_en low). Else write {ctr,hits,offset}, clear hits and trial. If offset+step > off_end or the 17-bit sum overflows -> DONE; else offset += step -> CLEAR.
  - DONE: set done, -> IDLE.
- hp_vcc_o and hp_pn_select_o follow CTRL at all times. Offset output holds the current offset while busy and 0 in IDLE.
- Abort in any state: next cycle IDLE, glitch_en=0, no push, done not set. FIFO contents kept.
- Start while busy: ignored.
- Simultaneous push and pop: both occur, count unchanged.
- RESULT read when empty: returns 0, no pointer change.

Test Plan:
1. Reset mid-ARM (glitch_en=1) -> all outputs 0 immediately; STATUS reads 0x0000_0004 after release.
2. RANGE=0x0014_0010, step=2, repeats=3, window=5, alarm forced high -> 3 results: offsets 0x10,0x12,0x14, hits=3 each. done=1. glitch_en high exactly 5 cycles per trial, 9 trials total.
3. off_start=0xFFFE, off_end=0xFFFF, step=4 -> single result at 0xFFFE, then DONE (no wrap).
4. 10-offset sweep with nothing read -> FSM stalls in PUSH with full=1 after 8 pushes. Two RESULT reads -> remaining 2 pushed, done=1, no data lost.
5. Abort during SETTLE of offset 3 -> IDLE next cycle, busy=0, done=0. FIFO holds offsets 0-2 only.
6. off_start>off_end, start -> done=1 within 2 cycles, FIFO empty. Read of word 0x18 -> data 0, ack after 1 cycle.
